// File: rtl/rsa_modexp_seq.sv
// Sequencer for C = M^E mod P using left-to-right square-and-multiply in the
// Montgomery domain, driving one shared multiplier over a start/done handshake.
module rsa_modexp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Const,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic             busy,
  output logic             eoc,
  output logic [WIDTH-1:0] C
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE_M = 3'd1,
    S_PRE_A = 3'd2,
    S_SQR   = 3'd3,
    S_MUL   = 3'd4,
    S_POST  = 3'd5
  } state_e;

  state_e           state_q;
  logic             issue_q;
  logic             pend_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mbar_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] const_q;
  logic [WIDTH-1:0] mm_a_q;
  logic [WIDTH-1:0] mm_b_q;
  logic             busy_q;
  logic             eoc_q;
  logic [WIDTH-1:0] c_q;

  logic             op_done;
  logic [WIDTH-1:0] op_res;
  logic             unused_p;

  // The modulus copy is held for the datapath's benefit; the sequencer itself never reads it.
  assign unused_p = ^p_q;

  assign mm_start = issue_q & ena;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign busy     = busy_q;
  assign eoc      = eoc_q;
  assign C        = c_q;

  // Completion seen in a WAIT phase, either live or parked while ena was low.
  always_comb begin
    op_done = 1'b0;
    op_res  = mm_result;
    if (state_q != S_IDLE && !issue_q) begin
      op_done = mm_done | pend_q;
      op_res  = pend_q ? res_q : mm_result;
    end else begin
      op_done = 1'b0;
      op_res  = mm_result;
    end
  end

  // Sequencer FSM; mm_a_q doubles as the accumulator A once PRE_A completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issue_q <= 1'b0;
      pend_q  <= 1'b0;
      res_q   <= '0;
      mbar_q  <= '0;
      idx_q   <= '0;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      const_q <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      c_q     <= '0;
    end else if (!ena) begin
      if (state_q != S_IDLE && !issue_q && mm_done && !pend_q) begin
        pend_q <= 1'b1;
        res_q  <= mm_result;
      end
    end else if (stop && busy_q) begin
      state_q <= S_IDLE;
      issue_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            p_q     <= P;
            e_q     <= E;
            m_q     <= M;
            const_q <= Const;
            busy_q  <= 1'b1;
            eoc_q   <= 1'b0;
            idx_q   <= IW'(WIDTH - 1);
            state_q <= S_PRE_M;
            issue_q <= 1'b1;
            mm_a_q  <= M;
            mm_b_q  <= Const;
          end
        end
        default: begin
          if (issue_q) begin
            issue_q <= 1'b0;
          end else if (op_done) begin
            pend_q  <= 1'b0;
            issue_q <= 1'b1;
            case (state_q)
              S_PRE_M: begin
                mbar_q  <= op_res;
                state_q <= S_PRE_A;
                mm_a_q  <= const_q;
                mm_b_q  <= ONE;
              end
              S_PRE_A: begin
                state_q <= S_SQR;
                mm_a_q  <= op_res;
                mm_b_q  <= op_res;
              end
              S_SQR: begin
                mm_a_q <= op_res;
                if (e_q[idx_q]) begin
                  state_q <= S_MUL;
                  mm_b_q  <= mbar_q;
                end else if (idx_q == '0) begin
                  state_q <= S_POST;
                  mm_b_q  <= ONE;
                end else begin
                  idx_q   <= idx_q - IW'(1);
                  state_q <= S_SQR;
                  mm_b_q  <= op_res;
                end
              end
              S_MUL: begin
                mm_a_q <= op_res;
                if (idx_q == '0) begin
                  state_q <= S_POST;
                  mm_b_q  <= ONE;
                end else begin
                  idx_q   <= idx_q - IW'(1);
                  state_q <= S_SQR;
                  mm_b_q  <= op_res;
                end
              end
              S_POST: begin
                c_q     <= op_res;
                eoc_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
                issue_q <= 1'b0;
                mm_a_q  <= '0;
                mm_b_q  <= '0;
              end
              default: begin
                state_q <= S_IDLE;
                issue_q <= 1'b0;
                busy_q  <= 1'b0;
                mm_a_q  <= '0;
                mm_b_q  <= '0;
              end
            endcase
          end else begin
            issue_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed bench for rsa_modexp_seq with a behavioural 3-cycle Montgomery multiplier.
module tb_rsa_modexp_seq;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop;
  logic [7:0] P, E, M, Const;
  logic       mm_start;
  logic [7:0] mm_a, mm_b;
  logic       mm_done = 1'b0;
  logic [7:0] mm_result = 8'd0;
  logic       busy, eoc;
  logic [7:0] C;

  always #5 clk = ~clk;

  rsa_modexp_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .P(P), .E(E), .M(M), .Const(Const),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_result(mm_result),
    .busy(busy), .eoc(eoc), .C(C)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         cnt_m = 0;
  logic [7:0] cap_a = 8'd0;
  logic [7:0] cap_b = 8'd0;
  int starts = 0;
  int starts_off = 0;
  int stab_err = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b);
    int rinv;
    rinv = 0;
    for (int x = 1; x < 13; x++) if (((256 * x) % 13) == 1) rinv = x;
    return 8'((int'(a) * int'(b) * rinv) % 13);
  endfunction

  // Multiplier model plus handshake monitor
  always @(posedge clk) begin
    if (mm_start) begin
      starts++;
      if (!ena) starts_off++;
    end
    if (mm_done) last_done_cyc = cyc;
    cyc++;
    if (cnt_m > 0 && busy && (mm_a !== cap_a || mm_b !== cap_b)) stab_err++;
    mm_done <= 1'b0;
    if (mm_start) begin
      cap_a <= mm_a;
      cap_b <= mm_b;
      cnt_m <= 2;
    end else if (cnt_m == 1) begin
      mm_done   <= 1'b1;
      mm_result <= mont(cap_a, cap_b);
      cnt_m     <= 0;
    end else if (cnt_m > 1) begin
      cnt_m <= cnt_m - 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_eoc"}, int'(eoc), 0);
    check({tag, "_C"}, int'(C), 0);
    check({tag, "_mm_a"}, int'(mm_a), 0);
    check({tag, "_mm_b"}, int'(mm_b), 0);
    check({tag, "_mm_start"}, int'(mm_start), 0);
  endtask

  task automatic start_op(input logic [7:0] m, input logic [7:0] e);
    @(negedge clk);
    P = 8'd13; Const = 8'd3; M = m; E = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    M = 8'hAA; E = 8'h55; P = 8'd0; Const = 8'd0;
  endtask

  task automatic wait_eoc(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 600) begin
      if (eoc) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  typedef struct {
    logic [7:0] m;
    logic [7:0] e;
    logic [7:0] exp_c;
    int         exp_ops;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int base, sbase, cprev, nst;

    // exp_ops = 3 + 8 + popcount(E); exp_c = M^E mod 13
    vecs[0] = '{8'd4,  8'd5,    8'd10, 13};
    vecs[1] = '{8'd7,  8'd0,    8'd1,  11};
    vecs[2] = '{8'd2,  8'hFF,   8'd8,  19};
    vecs[3] = '{8'd4,  8'd1,    8'd4,  12};
    vecs[4] = '{8'd12, 8'd2,    8'd1,  12};
    vecs[5] = '{8'd5,  8'h80,   8'd1,  12};
    vecs[6] = '{8'd3,  8'd3,    8'd1,  13};
    vecs[7] = '{8'd0,  8'd7,    8'd0,  14};

    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0;
    P = 8'd0; E = 8'd0; M = 8'd0; Const = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    for (int i = 0; i < 8; i++) begin
      base = starts;
      sbase = stab_err;
      start_op(vecs[i].m, vecs[i].e);
      wait_eoc(ok);
      check($sformatf("v%0d_timeout", i), int'(ok), 1);
      check($sformatf("v%0d_C", i), int'(C), int'(vecs[i].exp_c));
      check($sformatf("v%0d_ops", i), starts - base, vecs[i].exp_ops);
      check($sformatf("v%0d_busy", i), int'(busy), 0);
      check($sformatf("v%0d_eoc_lat", i), cyc, last_done_cyc + 1);
      check($sformatf("v%0d_stable", i), stab_err - sbase, 0);
      check($sformatf("v%0d_mm_a_idle", i), int'(mm_a), 0);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_eoc_sticky", i), int'(eoc), 1);
    end

    // Start and stop together from IDLE: stop wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    check("start_stop_eoc", int'(eoc), 1);

    // Abort during the 6th WAIT, then restart
    cprev = int'(C);
    base = starts;
    start_op(8'd4, 8'd5);
    nst = (mm_start) ? 1 : 0;
    while (nst < 6 && (starts - base) < 40) begin
      @(negedge clk);
      if (mm_start) nst++;
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ops_before", starts - base, 6);
    base = starts;
    repeat (10) @(negedge clk);
    check("abort_no_more_start", starts - base, 0);
    check("abort_C_kept", int'(C), cprev);
    check("abort_eoc_kept", int'(eoc), 0);
    check("abort_busy_after", int'(busy), 0);
    base = starts;
    start_op(8'd4, 8'd5);
    wait_eoc(ok);
    check("restart_timeout", int'(ok), 1);
    check("restart_C", int'(C), 10);
    check("restart_ops", starts - base, 13);

    // Enable held low for 20 cycles with a completion landing in the hold
    repeat (5) @(negedge clk);
    base = starts;
    sbase = starts_off;
    start_op(8'd4, 8'd5);
    nst = (mm_start) ? 1 : 0;
    while (nst < 4 && (starts - base) < 40) begin
      @(negedge clk);
      if (mm_start) nst++;
    end
    @(negedge clk);
    ena = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k == 5);
      stop  = (k == 10);
    end
    start = 1'b0; stop = 1'b0;
    check("hold_busy", int'(busy), 1);
    check("hold_ops_during", starts - base, 4);
    ena = 1'b1;
    wait_eoc(ok);
    check("hold_timeout", int'(ok), 1);
    check("hold_C", int'(C), 10);
    check("hold_ops", starts - base, 13);
    check("hold_no_start_off", starts_off - sbase, 0);

    // Synchronous reset mid-run, then a clean run
    repeat (5) @(negedge clk);
    start_op(8'd2, 8'hFF);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midreset");
    repeat (6) @(negedge clk);
    check("midreset_late_done_busy", int'(busy), 0);
    check("midreset_late_done_C", int'(C), 0);
    base = starts;
    start_op(8'd4, 8'd5);
    wait_eoc(ok);
    check("post_reset_timeout", int'(ok), 1);
    check("post_reset_C", int'(C), 10);
    check("post_reset_ops", starts - base, 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
